// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: reusable pipeline stage register with a two-entry skid
// buffer, registered valid/ready handshake, bubble-injecting flush and a
// saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int unsigned       WIDTH  = 70,
  parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{1'b0}},
  parameter int unsigned       CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  // Occupancy: EMPTY, ONE (main only), FULL (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               in_fire;
  logic               out_fire;

  // Handshakes are qualified only by registered flags, so in_ready never
  // depends combinationally on out_ready.
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  // Next-state, payload movement and flag decode.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    stall_d     = stall_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean empty stage.
        state_d = ST_EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase

    // Flush discards held entries and the payload offered this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);

    // Count back-pressured cycles on pre-edge values, saturating.
    if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State and payload registers; reset behaves as flush plus counter clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vector table, saturation/reset sequence and a
// randomized scoreboard run for pipe_stage_skid.
module tb_pipe_stage_skid;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [WIDTH-1:0] BUB = 8'hEE;
  localparam int unsigned NVEC = 20;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec;
  int n_err;

  pipe_stage_skid #(
    .WIDTH (WIDTH),
    .BUBBLE(BUB),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle and the outputs expected just after its edge.
  typedef struct {
    logic             rst;
    logic             flush;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ordy;
    logic             e_ov;
    logic             e_ir;
    logic [WIDTH-1:0] e_od;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [WIDTH-1:0] d, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic check_all(input string tag, input logic ov, input logic ir,
                           input logic [WIDTH-1:0] od, input logic [CNT_W-1:0] cnt);
    chk({tag, ".out_valid"}, 16'(out_valid), 16'(ov));
    chk({tag, ".in_ready"},  16'(in_ready),  16'(ir));
    chk({tag, ".out_data"},  16'(out_data),  16'(od));
    chk({tag, ".stall_cnt"}, 16'(stall_cnt), 16'(cnt));
  endtask

  // Reference model for the random phase.
  logic [WIDTH-1:0] q[$];
  int               m_cnt;
  logic [WIDTH-1:0] seq;

  initial begin
    string nm;
    logic  ir_before;
    logic  m_fin, m_fout;
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    //             rst flush iv  id     ordy  ov  ir  od     cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, BUB,   4'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, BUB,   4'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h02, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 4'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04, 4'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, BUB,   4'd0};
    // back-pressure: 0xA, 0xB accepted, 0xC held upstream
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 8'h0A, 4'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h0B, 1'b0, 1'b1, 1'b0, 8'h0A, 4'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b0, 8'h0A, 4'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 1'b1, 8'h0B, 4'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 1'b1, 8'h0C, 4'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, BUB,   4'd2};
    // flush while FULL with 0x55 offered
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 4'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 4'd3};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, BUB,   4'd4};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, BUB,   4'd4};
    // flush with out-fire of 0x7
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 4'd4};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, BUB,   4'd4};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 4'd4};

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      @(posedge clk);
      #1;
      nm = $sformatf("vec%0d", i);
      check_all(nm, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_od, vecs[i].e_cnt);
    end

    // Saturation: 20 stalled cycles holding 0x33, counter stops at 15.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      nm = $sformatf("sat%0d", k);
      check_all(nm, 1'b1, 1'b1, 8'h33, CNT_W'((5 + k > 15) ? 15 : 5 + k));
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_all("sat_flush", 1'b0, 1'b1, BUB, 4'd15);
    drive(1'b1, 1'b1, 1'b1, 8'h44, 1'b1);
    @(posedge clk);
    #1;
    check_all("rst_flush", 1'b0, 1'b1, BUB, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    check_all("post_rst", 1'b0, 1'b1, BUB, 4'd0);

    // Random phase against a queue scoreboard.
    q.delete();
    m_cnt = 0;
    seq   = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      drive(1'b0, ($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
            seq, $urandom_range(0, 2) != 0);
      if ((c % 16) == 0) begin
        ir_before = in_ready;
        #1 out_ready = ~out_ready;
        #1 chk("ir_indep_of_ordy", 16'(in_ready), 16'(ir_before));
        out_ready = ~out_ready;
      end
      m_fin  = in_valid && (q.size() < 2);
      m_fout = (q.size() > 0) && out_ready;
      @(posedge clk);
      #1;
      if ((q.size() > 0) && !out_ready && (m_cnt != 15)) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_fout) void'(q.pop_front());
        if (m_fin) begin
          q.push_back(seq);
          seq = seq + 8'h01;
        end
      end
      check_all("rand", q.size() > 0, q.size() < 2,
                (q.size() > 0) ? q[0] : BUB, CNT_W'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register replacing the hard-wired per-stage registers (IF/ID, ID/EX, …) with one reusable block. Carries an arbitrary-width payload under a valid/ready handshake, absorbs back-pressure with a two-entry skid buffer so `in_ready` is a registered signal, and supports a flush that injects a bubble payload. A saturating stall counter gives per-stage performance visibility.

## Interface
Parameters:
- `WIDTH`, 70, payload width in bits (pc + inst + control bits for the IF/ID instance).
- `BUBBLE`, `{WIDTH{1'b0}}`, payload presented on `out_data` when the stage holds nothing.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept; driven only from state registers.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a real entry.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  head payload, driven directly from a register.
- `flush`  in  1  discard all held entries and the current input.
- `stall_cnt`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage: main register (drives `out_data`) and skid register; state encodes occupancy: EMPTY (0), ONE (main only), FULL (main + skid).
- In-fire = `in_valid & in_ready`; out-fire = `out_valid & out_ready`.
- `out_valid` = state is ONE or FULL; `in_ready` = state is not FULL.
- Transitions (no flush, no reset):
  - EMPTY: in-fire → ONE, main ← `in_data`; else stay EMPTY. `out_ready` is ignored.
  - ONE: in-fire & out-fire → ONE, main ← `in_data`; in-fire only → FULL, skid ← `in_data`; out-fire only → EMPTY, main ← BUBBLE; neither → hold.
  - FULL: `in_ready` is 0; out-fire → ONE, main ← skid, skid ← BUBBLE; else hold.
- Flush (priority below reset, above all handshakes): next state EMPTY, main and skid ← BUBBLE. The payload offered in the flush cycle is discarded even if `in_ready` was 1; upstream treats it as consumed. A downstream out-fire in the flush cycle is still a valid transfer of the pre-flush head.
- Reset: identical to flush, plus `stall_cnt` ← 0.
- Order is preserved; no entry is ever duplicated or dropped outside flush/reset.
- `stall_cnt`: +1 each cycle with `out_valid & ~out_ready`, evaluated on pre-edge values; saturates at all-ones; cleared only by `rst`; flush does not clear it.

## Timing
- Reset values: `out_valid` 0, `in_ready` 1, `out_data` BUBBLE, `stall_cnt` 0; state EMPTY.
- Latency: an entry accepted at edge N appears on `out_data`/`out_valid` after edge N (1 cycle) when the stage was EMPTY or ONE-with-out-fire.
- Throughput: 1 entry/cycle sustained while `out_ready` = 1.
- `in_ready` falls the cycle after the stage becomes FULL; the skid entry absorbs the one payload already in flight, so no combinational path from `out_ready` to `in_ready`.
- After `out_ready` returns high in FULL: head leaves at that edge, `in_ready` is 1 in the next cycle.
- Flush takes effect at the edge it is sampled; `out_valid` = 0 and `out_data` = BUBBLE the following cycle.
- `rst` and `flush` together: reset behaviour.

## Test plan
- Reset then stream: `rst` for 2 cycles, then `in_data` = 1,2,3,4 back-to-back with `out_ready` = 1 → `out_data` 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance; `stall_cnt` = 0.
- Back-pressure: push 0xA, 0xB, 0xC with `out_ready` = 0 → 0xA and 0xB accepted, `in_ready` = 0 from the cycle after 0xB; 0xC is held upstream. Then `out_ready` = 1 → output 0xA, 0xB, 0xC in order, no loss; `stall_cnt` equals the count of low-`out_ready` cycles with `out_valid` = 1.
- Flush while FULL with `in_valid` = 1 (payload 0x55) → next cycle `out_valid` = 0, `out_data` = BUBBLE, `in_ready` = 1; 0x55 never appears at the output.
- Flush with out-fire: ONE holding 0x7 and `out_ready` = 1 in the flush cycle → 0x7 is counted as delivered; the stage is EMPTY afterwards.
- Saturation: `CNT_W` = 4, hold `out_valid` = 1 and `out_ready` = 0 for 20 cycles → `stall_cnt` stops at 15; a flush leaves it at 15, `rst` clears it to 0.
- Random: random `in_valid`/`out_ready`/rare `flush` for 10k cycles against a scoreboard queue → in-order delivery, no duplicates, and `in_ready` never depends combinationally on `out_ready`.
